// File: rtl/dac_start_pkg.sv
// Shared definitions for the DAC start sequencer: state encoding,
// startDAC register field positions and status word field positions.
package dac_start_pkg;

    // Sequencer states; codes are visible in the status word and must not move.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_DELAY     = 3'd3,
        ST_RUN       = 3'd4
    } dac_state_e;

    // startDAC register fields
    localparam int REG_START_BIT     = 0;
    localparam int REG_STOP_BIT      = 1;
    localparam int REG_SYNC_MODE_BIT = 2;
    localparam int REG_DELAY_LSB     = 16;
    localparam int REG_DELAY_W       = 16;

    // Number of low register bits that go through the edge detector (start, stop)
    localparam int NUM_CMD_BITS      = 2;

    // Status word fields
    localparam int STAT_STATE_LSB    = 0;
    localparam int STAT_STATE_W      = 3;
    localparam int STAT_TIMEOUT_BIT  = 3;
    localparam int STAT_READY_BIT    = 4;
    localparam int STAT_COUNT_LSB    = 16;
    localparam int STAT_COUNT_W      = 16;

    // Saturating 16-bit increment used by the start counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Assemble the readback status word from its fields
    function automatic logic [31:0] pack_status(
        input dac_state_e  st,
        input logic        to_flag,
        input logic        ready,
        input logic [15:0] cnt
    );
        logic [31:0] s;
        s = '0;
        s[STAT_STATE_LSB +: STAT_STATE_W] = st;
        s[STAT_TIMEOUT_BIT]               = to_flag;
        s[STAT_READY_BIT]                 = ready;
        s[STAT_COUNT_LSB +: STAT_COUNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/dac_start_seq.sv
// DAC start sequencer: edge-detects start/stop from the startDAC register and
// walks IDLE -> RESET -> (WAIT_SYNC) -> (DELAY) -> RUN, driving the DAC reset,
// DAC enable and a LUT re-alignment pulse. All outputs are registered decodes
// of the next state so they switch on the same edge as the state register.
// Optional feature macro: DAC_START_TIMEOUT_EN -- when defined, WAIT_SYNC gives
// up after TIMEOUT_CYCLES cycles without a sync pulse and flags it in status[3].
module dac_start_seq
    import dac_start_pkg::*;
#(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] reg_data,
    input  logic        sync_in,
    input  logic        dac_ready,
    output logic        dac_rst,
    output logic        dac_en,
    output logic        lut_sync,
    output logic [31:0] status
);

    // RST_CYCLES is limited to 1..255, so an 8-bit down-counter is enough
    localparam logic [7:0] RST_CNT_INIT = 8'(RST_CYCLES - 1);

    // Register input pipeline and derived command pulses
    logic [31:0]             data_q;
    logic [NUM_CMD_BITS-1:0] data_qq;
    logic [NUM_CMD_BITS-1:0] cmd_pulse;
    logic                    start_pulse;
    logic                    stop_pulse;
    logic                    sync_mode;
    logic [REG_DELAY_W-1:0]  delay_val;
    logic                    sync_q;

    // Sequencer state
    dac_state_e  state_reg, state_next;
    logic [7:0]  rst_cnt_reg, rst_cnt_next;
    logic [15:0] dly_cnt_reg, dly_cnt_next;
    logic [15:0] start_cnt_reg, start_cnt_next;
    logic        run_entry;
    logic        timeout_flag_next;

    // Register bits that carry no function here are folded away explicitly
    logic        unused_bits;
    assign unused_bits = ^{data_q[REG_DELAY_LSB-1:REG_SYNC_MODE_BIT+1], (TIMEOUT_CYCLES > 0)};

    // Two-stage capture of the register value and the sync pulse
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            data_q  <= '0;
            data_qq <= '0;
            sync_q  <= 1'b0;
        end else begin
            data_q  <= reg_data;
            data_qq <= data_q[NUM_CMD_BITS-1:0];
            sync_q  <= sync_in;
        end
    end

    // Rising-edge detect on the start and stop bits
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMD_BITS; gi++) begin : g_cmd_edge
            assign cmd_pulse[gi] = data_q[gi] & ~data_qq[gi];
        end
    endgenerate

    assign start_pulse = cmd_pulse[REG_START_BIT];
    assign stop_pulse  = cmd_pulse[REG_STOP_BIT];
    assign sync_mode   = data_q[REG_SYNC_MODE_BIT];
    assign delay_val   = data_q[REG_DELAY_LSB +: REG_DELAY_W];

`ifdef DAC_START_TIMEOUT_EN
    // Counter width just large enough to hold TIMEOUT_CYCLES-1
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            timeout_reg;
`endif

    // Next-state and counter logic; stop has priority over every state
    always_comb begin
        state_next        = state_reg;
        rst_cnt_next      = rst_cnt_reg;
        dly_cnt_next      = dly_cnt_reg;
`ifdef DAC_START_TIMEOUT_EN
        to_cnt_next       = to_cnt_reg;
        timeout_flag_next = timeout_reg;
`else
        timeout_flag_next = 1'b0;
`endif
        if (stop_pulse) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_pulse) begin
                        state_next        = ST_RESET;
                        rst_cnt_next      = RST_CNT_INIT;
                        timeout_flag_next = 1'b0;
                    end
                end
                ST_RESET: begin
                    if (rst_cnt_reg != 8'd0) begin
                        rst_cnt_next = rst_cnt_reg - 8'd1;
                    end else if (dac_ready) begin
                        // Reset time served and DAC locked: pick the release path
                        if (sync_mode) begin
                            state_next = ST_WAIT_SYNC;
`ifdef DAC_START_TIMEOUT_EN
                            to_cnt_next = '0;
`endif
                        end else if (delay_val != '0) begin
                            state_next   = ST_DELAY;
                            dly_cnt_next = delay_val - 16'd1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_WAIT_SYNC: begin
                    if (sync_q) begin
                        if (delay_val != '0) begin
                            state_next   = ST_DELAY;
                            dly_cnt_next = delay_val - 16'd1;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end
`ifdef DAC_START_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        state_next        = ST_IDLE;
                        timeout_flag_next = 1'b1;
                    end else begin
                        to_cnt_next = to_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_DELAY: begin
                    // Loaded with delay-1, so the state lasts exactly delay cycles
                    if (dly_cnt_reg == 16'd0) begin
                        state_next = ST_RUN;
                    end else begin
                        dly_cnt_next = dly_cnt_reg - 16'd1;
                    end
                end
                ST_RUN: begin
                    state_next = ST_RUN;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // A RUN entry restarts the LUT and bumps the saturating start count
    assign run_entry      = (state_next == ST_RUN) && (state_reg != ST_RUN);
    assign start_cnt_next = run_entry ? sat_inc16(start_cnt_reg) : start_cnt_reg;

`ifdef DAC_START_TIMEOUT_EN
    // WAIT_SYNC timeout counter and sticky timeout flag
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            timeout_reg <= timeout_flag_next;
        end
    end
`endif

    // State, counters and Moore outputs decoded from the next state
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_reg     <= ST_IDLE;
            rst_cnt_reg   <= '0;
            dly_cnt_reg   <= '0;
            start_cnt_reg <= '0;
            dac_rst       <= 1'b0;
            dac_en        <= 1'b0;
            lut_sync      <= 1'b0;
            status        <= '0;
        end else begin
            state_reg     <= state_next;
            rst_cnt_reg   <= rst_cnt_next;
            dly_cnt_reg   <= dly_cnt_next;
            start_cnt_reg <= start_cnt_next;
            dac_rst       <= (state_next == ST_RESET);
            dac_en        <= (state_next == ST_RUN);
            lut_sync      <= run_entry;
            status        <= pack_status(state_next, timeout_flag_next, dac_ready, start_cnt_next);
        end
    end

endmodule
